// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data sides, data side first, one transaction in flight
module mem_arbiter #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  input  logic [3:0]  d_req_we,
  input  logic [31:0] d_req_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic [3:0]  mem_req_we,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        stall,
  output logic        err
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;
  state_t state, state_n;
  logic          owner_d;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    we_q;
  logic [CW-1:0] cnt;
  logic          grant_d, grant_i, accept, tmo, fin;
  logic [31:0]   rd;
  // a done pulse in flight blocks every grant, so the finished requester can drop valid first
  always_comb begin
    state_n = state;
    grant_d = 1'b0;
    grant_i = 1'b0;
    accept  = 1'b0;
    tmo     = 1'b0;
    fin     = 1'b0;
    case (state)
      IDLE: begin
        grant_d = d_req_valid & ~d_done & ~i_done;
        grant_i = i_req_valid & ~i_done & ~d_done & ~grant_d;
        state_n = (grant_d | grant_i) ? ISSUE : IDLE;
      end
      ISSUE: begin
        accept  = mem_req_ready;
        fin     = mem_req_ready & |we_q;
        state_n = !mem_req_ready ? ISSUE : (|we_q ? IDLE : WAIT_RESP);
      end
      WAIT_RESP: begin
        tmo     = ~mem_resp_valid & (cnt == CW'(TIMEOUT - 2));
        fin     = mem_resp_valid | tmo;
        state_n = fin ? IDLE : WAIT_RESP;
      end
      default: state_n = IDLE;
    endcase
  end
  assign rd            = tmo ? ERR_DATA : mem_resp_data;
  assign mem_req_valid = state == ISSUE;
  assign mem_req_addr  = mem_req_valid ? addr_q : 32'd0;
  assign mem_req_we    = mem_req_valid ? we_q : 4'd0;
  assign mem_req_wdata = mem_req_valid ? wdata_q : 32'd0;
  assign stall         = (i_req_valid & ~i_done) | (d_req_valid & ~d_done);
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      addr_q  <= 32'd0;
      we_q    <= 4'd0;
      wdata_q <= 32'd0;
      cnt     <= '0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_rdata <= 32'd0;
      d_rdata <= 32'd0;
      err     <= 1'b0;
    end else begin
      state  <= state_n;
      i_done <= fin & ~owner_d;
      d_done <= fin & owner_d;
      if (grant_d | grant_i) begin
        owner_d <= grant_d;
        addr_q  <= grant_d ? d_req_addr : i_req_addr;
        we_q    <= grant_d ? d_req_we : 4'd0;
        wdata_q <= grant_d ? d_req_wdata : 32'd0;
      end
      if (accept)
        cnt <= '0;
      else if (state == WAIT_RESP && !mem_resp_valid && cnt != '1)
        cnt <= cnt + CW'(1);
      if (state == WAIT_RESP && fin && owner_d)
        d_rdata <= rd;
      if (state == WAIT_RESP && fin && !owner_d)
        i_rdata <= rd;
      if (tmo)
        err <= 1'b1;
    end
  end
endmodule
